// File: rtl/bike_divider.sv
// Shared iterative unsigned divider for the speed and average-speed requesters.
// Restoring division producing one quotient bit per clock, with a start/busy/ready handshake.
module bike_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // quo_q starts out holding the dividend; its MSBs shift into the partial
    // remainder while quotient bits fill in from the bottom.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]};
        fits     = (trial >= {1'b0, div_q});
        rem_next = fits ? WIDTH'(trial - {1'b0, div_q}) : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            result      <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            ready       <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quo_q <= dividend;
                            div_q <= divisor;
                            rem_q <= '0;
                            count <= CW'(WIDTH - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result      <= quo_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        ready       <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Busy stays high until the requester drops start, so no
                    // other requester can load operands in the meantime.
                    if (!start) begin
                        busy  <= 1'b0;
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
